// File: rtl/bp_fe_bht_update_queue_if.sv
// Bundle of the update-queue signals shared by the backend, the queue and
// the BHT write port.
//   flush_i, bht_init_done_i : control into the queue
//   upd_*                    : resolved-branch update (valid/ready)
//   w_*                      : head entry to the BHT (valid/yumi)
//   count_o, starve_o        : occupancy and starvation status
// slave  : the queue's view
// master : the environment's view (backend + BHT)
interface bp_fe_bht_update_queue_if #(
  parameter int bht_idx_width_p    = 9,
  parameter int bht_offset_width_p = 1,
  parameter int ghist_width_p      = 2,
  parameter int bht_row_width_p    = 4,
  parameter int els_p              = 4
);
  logic                          flush_i;
  logic                          bht_init_done_i;

  logic                          upd_v_i;
  logic                          upd_ready_o;
  logic [bht_idx_width_p-1:0]    upd_idx_i;
  logic [bht_offset_width_p-1:0] upd_offset_i;
  logic [ghist_width_p-1:0]      upd_ghist_i;
  logic [bht_row_width_p-1:0]    upd_val_i;
  logic                          upd_correct_i;

  logic                          w_v_o;
  logic [bht_idx_width_p-1:0]    w_idx_o;
  logic [bht_offset_width_p-1:0] w_offset_o;
  logic [ghist_width_p-1:0]      w_ghist_o;
  logic [bht_row_width_p-1:0]    w_val_o;
  logic                          w_correct_o;
  logic                          w_yumi_i;

  logic [$clog2(els_p+1)-1:0]    count_o;
  logic                          starve_o;

  modport slave (
    input  flush_i, bht_init_done_i,
    input  upd_v_i, upd_idx_i, upd_offset_i, upd_ghist_i, upd_val_i, upd_correct_i,
    output upd_ready_o,
    output w_v_o, w_idx_o, w_offset_o, w_ghist_o, w_val_o, w_correct_o,
    input  w_yumi_i,
    output count_o, starve_o
  );

  modport master (
    output flush_i, bht_init_done_i,
    output upd_v_i, upd_idx_i, upd_offset_i, upd_ghist_i, upd_val_i, upd_correct_i,
    input  upd_ready_o,
    input  w_v_o, w_idx_o, w_offset_o, w_ghist_o, w_val_o, w_correct_o,
    output w_yumi_i,
    input  count_o, starve_o
  );
endinterface

// File: rtl/bp_fe_bht_update_queue.sv
// BHT update queue: buffers resolved-branch BHT updates and drains them in
// strict FIFO order into the BHT write port, holding them across cycles in
// which the BHT refuses a write (init sweep, read/write collisions).
//   clk_i      : clock
//   reset_n_i  : synchronous active-low reset
//   bus        : slave side of bp_fe_bht_update_queue_if (update input,
//                head-entry output, flush, init-done, count, starve)
module bp_fe_bht_update_queue #(
  parameter int bht_idx_width_p    = 9,
  parameter int bht_offset_width_p = 1,
  parameter int ghist_width_p      = 2,
  parameter int bht_row_width_p    = 4,
  parameter int els_p              = 4,
  parameter int starve_thresh_p    = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  bp_fe_bht_update_queue_if.slave     bus
);

  localparam int addr_w   = $clog2(els_p);
  localparam int ptr_w    = addr_w + 1;
  localparam int cnt_w    = $clog2(els_p + 1);
  localparam int starve_w = $clog2(starve_thresh_p + 1);
  localparam int entry_w  = ghist_width_p + bht_idx_width_p + bht_offset_width_p
                          + bht_row_width_p + 1;

  typedef enum logic {e_wait, e_run} state_e;

  state_e                state_reg, state_next;
  logic [ptr_w-1:0]      rptr_reg, rptr_next;
  logic [ptr_w-1:0]      wptr_reg, wptr_next;
  logic [starve_w-1:0]   starve_cnt_reg, starve_cnt_next;

  // Small LUT-style storage read asynchronously so the head entry is visible
  // the cycle after it is written (1-cycle enqueue-to-valid latency).
  logic [entry_w-1:0]    mem [els_p];
  logic [entry_w-1:0]    head;

  logic empty, full, enq, deq, w_v;

  assign empty = (rptr_reg == wptr_reg);
  // Full when the pointers alias the same slot but are a lap apart.
  assign full  = (rptr_reg[addr_w] != wptr_reg[addr_w])
              && (rptr_reg[addr_w-1:0] == wptr_reg[addr_w-1:0]);

  assign w_v = (state_reg == e_run) && !empty;

  assign bus.upd_ready_o = reset_n_i & ~full & ~bus.flush_i;
  assign enq = bus.upd_v_i & bus.upd_ready_o;
  // A yumi without a valid head is illegal and simply ignored here.
  assign deq = bus.w_yumi_i & w_v;

  // Control FSM: hold the head back from the BHT until its init sweep is done.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      e_wait:  if (bus.bht_init_done_i)  state_next = e_run;
      e_run:   if (!bus.bht_init_done_i) state_next = e_wait;
      default: state_next = e_wait;
    endcase
  end

  // Flush wins over both enqueue and dequeue.
  always_comb begin
    rptr_next = rptr_reg;
    wptr_next = wptr_reg;
    if (bus.flush_i) begin
      rptr_next = '0;
      wptr_next = '0;
    end else begin
      if (enq) wptr_next = wptr_reg + ptr_w'(1);
      if (deq) rptr_next = rptr_reg + ptr_w'(1);
    end
  end

  // Counts consecutive cycles the head sat refused; saturates at threshold.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (bus.flush_i || bus.w_yumi_i || empty || (state_reg == e_wait)) begin
      starve_cnt_next = '0;
    end else if (w_v && (starve_cnt_reg != starve_w'(starve_thresh_p))) begin
      starve_cnt_next = starve_cnt_reg + starve_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg      <= e_wait;
      rptr_reg       <= '0;
      wptr_reg       <= '0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rptr_reg       <= rptr_next;
      wptr_reg       <= wptr_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Entry storage has no reset; enq is already gated off during reset.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wptr_reg[addr_w-1:0]] <= {bus.upd_ghist_i, bus.upd_idx_i, bus.upd_offset_i,
                                    bus.upd_val_i, bus.upd_correct_i};
    end
  end

  assign head = mem[rptr_reg[addr_w-1:0]];

  assign {bus.w_ghist_o, bus.w_idx_o, bus.w_offset_o, bus.w_val_o, bus.w_correct_o} = head;
  assign bus.w_v_o    = w_v;
  assign bus.count_o  = cnt_w'(wptr_reg - rptr_reg);
  assign bus.starve_o = (starve_cnt_reg == starve_w'(starve_thresh_p));

  yumi_needs_valid_a: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) bus.w_yumi_i |-> w_v
  );

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Directed testbench for bp_fe_bht_update_queue (default parameters).
// Inputs are driven 1 time unit after each rising edge; outputs are
// sampled at that same point, well away from the active edge.
module tb_bp_fe_bht_update_queue;

  typedef struct packed {
    logic [1:0] gh;
    logic [8:0] idx;
    logic       off;
    logic [3:0] val;
    logic       corr;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bp_fe_bht_update_queue_if bus ();

  bp_fe_bht_update_queue dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ent_t e);
    bus.upd_v_i       = 1'b1;
    bus.upd_ghist_i   = e.gh;
    bus.upd_idx_i     = e.idx;
    bus.upd_offset_i  = e.off;
    bus.upd_val_i     = e.val;
    bus.upd_correct_i = e.corr;
  endtask

  function automatic ent_t head_ent();
    return {bus.w_ghist_o, bus.w_idx_o, bus.w_offset_o, bus.w_val_o, bus.w_correct_o};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.upd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.upd_ready_o); end
    checks++; if (bus.w_v_o !== 1'b0) begin errors++; $display("FAIL rst_wv got %b want 0", bus.w_v_o); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", bus.count_o); end
    checks++; if (bus.starve_o !== 1'b0) begin errors++; $display("FAIL rst_starve got %b want 0", bus.starve_o); end
    reset_n = 1'b1;
    #1;
    checks++; if (bus.upd_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", bus.upd_ready_o); end
    $display("test_reset done");
  endtask

  task automatic test_init_gate();
    ent_t e [3];
    e[0] = '{gh: 2'b10, idx: 9'h1A3, off: 1'b1, val: 4'h5, corr: 1'b1};
    e[1] = '{gh: 2'b01, idx: 9'h042, off: 1'b0, val: 4'hA, corr: 1'b0};
    e[2] = '{gh: 2'b11, idx: 9'h1FF, off: 1'b1, val: 4'h3, corr: 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(e[i]);
      tick();
    end
    bus.upd_v_i = 1'b0;
    checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL init_count got %0d want 3", bus.count_o); end
    checks++; if (bus.w_v_o !== 1'b0) begin errors++; $display("FAIL init_wv_held got %b want 0", bus.w_v_o); end
    tick();
    checks++; if (bus.w_v_o !== 1'b0) begin errors++; $display("FAIL init_wv_held2 got %b want 0", bus.w_v_o); end
    bus.bht_init_done_i = 1'b1;
    #1;
    checks++; if (bus.w_v_o !== 1'b0) begin errors++; $display("FAIL init_wv_same_cycle got %b want 0", bus.w_v_o); end
    tick();
    checks++; if (bus.w_v_o !== 1'b1) begin errors++; $display("FAIL init_wv_rise got %b want 1", bus.w_v_o); end
    checks++; if (head_ent() !== e[0]) begin errors++; $display("FAIL init_head0 got %h want %h", head_ent(), e[0]); end
    bus.w_yumi_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.count_o !== 3'(2 - k)) begin errors++; $display("FAIL drain_count%0d got %0d want %0d", k, bus.count_o, 2 - k); end
      if (k < 2) begin
        checks++; if (head_ent() !== e[k+1]) begin errors++; $display("FAIL drain_head%0d got %h want %h", k + 1, head_ent(), e[k+1]); end
      end
    end
    bus.w_yumi_i = 1'b0;
    checks++; if (bus.w_v_o !== 1'b0) begin errors++; $display("FAIL drain_wv_empty got %b want 0", bus.w_v_o); end
    $display("test_init_gate done");
  endtask

  task automatic test_full();
    ent_t f [5];
    f[0] = '{gh: 2'b00, idx: 9'h011, off: 1'b0, val: 4'h1, corr: 1'b1};
    f[1] = '{gh: 2'b01, idx: 9'h022, off: 1'b1, val: 4'h2, corr: 1'b0};
    f[2] = '{gh: 2'b10, idx: 9'h033, off: 1'b0, val: 4'h4, corr: 1'b1};
    f[3] = '{gh: 2'b11, idx: 9'h144, off: 1'b1, val: 4'h8, corr: 1'b0};
    f[4] = '{gh: 2'b10, idx: 9'h155, off: 1'b0, val: 4'hF, corr: 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(f[i]);
      tick();
    end
    drive(f[4]);
    #1;
    checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", bus.count_o); end
    checks++; if (bus.upd_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", bus.upd_ready_o); end
    checks++; if (head_ent() !== f[0]) begin errors++; $display("FAIL full_head got %h want %h", head_ent(), f[0]); end
    bus.w_yumi_i = 1'b1;
    tick();
    bus.w_yumi_i = 1'b0;
    #1;
    checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL full_yumi_count got %0d want 3", bus.count_o); end
    checks++; if (bus.upd_ready_o !== 1'b1) begin errors++; $display("FAIL full_reopen_ready got %b want 1", bus.upd_ready_o); end
    tick();
    bus.upd_v_i = 1'b0;
    checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL full_refill_count got %0d want 4", bus.count_o); end
    bus.w_yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (head_ent() !== f[k+1]) begin errors++; $display("FAIL full_order%0d got %h want %h", k, head_ent(), f[k+1]); end
      tick();
    end
    bus.w_yumi_i = 1'b0;
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", bus.count_o); end
    $display("test_full done");
  endtask

  task automatic test_starve();
    ent_t g;
    g = '{gh: 2'b01, idx: 9'h0F0, off: 1'b1, val: 4'h6, corr: 1'b0};
    drive(g);
    tick();
    bus.upd_v_i = 1'b0;
    checks++; if (bus.w_v_o !== 1'b1) begin errors++; $display("FAIL starve_wv got %b want 1", bus.w_v_o); end
    checks++; if (bus.starve_o !== 1'b0) begin errors++; $display("FAIL starve_c0 got %b want 0", bus.starve_o); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++; if (bus.starve_o !== (k >= 8)) begin errors++; $display("FAIL starve_c%0d got %b want %b", k, bus.starve_o, (k >= 8)); end
    end
    bus.w_yumi_i = 1'b1;
    tick();
    bus.w_yumi_i = 1'b0;
    checks++; if (bus.starve_o !== 1'b0) begin errors++; $display("FAIL starve_clear got %b want 0", bus.starve_o); end
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL starve_count got %0d want 0", bus.count_o); end
    $display("test_starve done");
  endtask

  task automatic test_flush();
    ent_t h [4];
    h[0] = '{gh: 2'b11, idx: 9'h101, off: 1'b0, val: 4'h9, corr: 1'b1};
    h[1] = '{gh: 2'b00, idx: 9'h102, off: 1'b1, val: 4'hC, corr: 1'b0};
    h[2] = '{gh: 2'b01, idx: 9'h103, off: 1'b0, val: 4'h7, corr: 1'b1};
    h[3] = '{gh: 2'b10, idx: 9'h0AB, off: 1'b1, val: 4'hE, corr: 1'b0};
    drive(h[0]); tick();
    drive(h[1]); tick();
    checks++; if (bus.count_o !== 3'd2) begin errors++; $display("FAIL flush_pre_count got %0d want 2", bus.count_o); end
    bus.flush_i  = 1'b1;
    bus.w_yumi_i = 1'b1;
    drive(h[2]);
    #1;
    checks++; if (bus.upd_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", bus.upd_ready_o); end
    tick();
    bus.flush_i  = 1'b0;
    bus.w_yumi_i = 1'b0;
    bus.upd_v_i  = 1'b0;
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.count_o); end
    checks++; if (bus.w_v_o !== 1'b0) begin errors++; $display("FAIL flush_wv got %b want 0", bus.w_v_o); end
    drive(h[3]);
    tick();
    bus.upd_v_i = 1'b0;
    checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL flush_after_count got %0d want 1", bus.count_o); end
    checks++; if (head_ent() !== h[3]) begin errors++; $display("FAIL flush_dropped got %h want %h", head_ent(), h[3]); end
    bus.w_yumi_i = 1'b1;
    tick();
    bus.w_yumi_i = 1'b0;
    $display("test_flush done");
  endtask

  task automatic test_back_to_back();
    ent_t sb [$];
    ent_t e;
    e = '{gh: 2'b01, idx: 9'h0C3, off: 1'b0, val: 4'hB, corr: 1'b1};
    drive(e);
    sb.push_back(e);
    tick();
    for (int i = 0; i < 20; i++) begin
      e.gh   = 2'($urandom_range(0, 3));
      e.idx  = 9'($urandom_range(0, 511));
      e.off  = 1'($urandom_range(0, 1));
      e.val  = 4'($urandom_range(0, 15));
      e.corr = 1'($urandom_range(0, 1));
      drive(e);
      bus.w_yumi_i = 1'b1;
      checks++; if (head_ent() !== sb[0]) begin errors++; $display("FAIL b2b_head%0d got %h want %h", i, head_ent(), sb[0]); end
      checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL b2b_count%0d got %0d want 1", i, bus.count_o); end
      tick();
      void'(sb.pop_front());
      sb.push_back(e);
    end
    bus.upd_v_i = 1'b0;
    checks++; if (head_ent() !== sb[0]) begin errors++; $display("FAIL b2b_last got %h want %h", head_ent(), sb[0]); end
    tick();
    bus.w_yumi_i = 1'b0;
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d want 0", bus.count_o); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    ent_t k0;
    k0 = '{gh: 2'b11, idx: 9'h077, off: 1'b1, val: 4'hD, corr: 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive('{gh: 2'(i), idx: 9'(i + 16), off: 1'b0, val: 4'(i), corr: 1'b1});
      tick();
    end
    bus.upd_v_i = 1'b0;
    checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL rmid_pre_count got %0d want 3", bus.count_o); end
    reset_n = 1'b0;
    bus.bht_init_done_i = 1'b0;
    #1;
    checks++; if (bus.upd_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b want 0", bus.upd_ready_o); end
    tick();
    reset_n = 1'b1;
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", bus.count_o); end
    checks++; if (bus.w_v_o !== 1'b0) begin errors++; $display("FAIL rmid_wv got %b want 0", bus.w_v_o); end
    checks++; if (bus.starve_o !== 1'b0) begin errors++; $display("FAIL rmid_starve got %b want 0", bus.starve_o); end
    drive(k0);
    tick();
    bus.upd_v_i = 1'b0;
    checks++; if (bus.count_o !== 3'd1) begin errors++; $display("FAIL rmid_enq_count got %0d want 1", bus.count_o); end
    checks++; if (bus.w_v_o !== 1'b0) begin errors++; $display("FAIL rmid_wait_wv got %b want 0", bus.w_v_o); end
    tick();
    checks++; if (bus.w_v_o !== 1'b0) begin errors++; $display("FAIL rmid_wait_wv2 got %b want 0", bus.w_v_o); end
    bus.bht_init_done_i = 1'b1;
    tick();
    checks++; if (bus.w_v_o !== 1'b1) begin errors++; $display("FAIL rmid_run_wv got %b want 1", bus.w_v_o); end
    checks++; if (head_ent() !== k0) begin errors++; $display("FAIL rmid_head got %h want %h", head_ent(), k0); end
    bus.w_yumi_i = 1'b1;
    tick();
    bus.w_yumi_i = 1'b0;
    checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL rmid_drain got %0d want 0", bus.count_o); end
    $display("test_reset_mid done");
  endtask

  initial begin
    reset_n             = 1'b0;
    bus.flush_i         = 1'b0;
    bus.bht_init_done_i = 1'b0;
    bus.upd_v_i         = 1'b0;
    bus.upd_idx_i       = '0;
    bus.upd_offset_i    = '0;
    bus.upd_ghist_i     = '0;
    bus.upd_val_i       = '0;
    bus.upd_correct_i   = 1'b0;
    bus.w_yumi_i        = 1'b0;

    test_reset();
    test_init_gate();
    test_full();
    test_starve();
    test_flush();
    test_back_to_back();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_update_queue.md
# bp_fe_bht_update_queue

Buffers resolved-branch BHT updates from the backend redirect/commit path and drains them into the BHT write port. The BHT may refuse a write in any cycle: during its init sweep, or on a same-address read/write collision, when it withholds its write-accept. This queue holds updates across those refusals so none are lost, and it flags sustained starvation so the fetch logic can yield a read slot.

## Interface
Parameters:
- `bht_idx_width_p`, default 9: BHT row index width.
- `bht_offset_width_p`, default 1: counter offset within a row.
- `ghist_width_p`, default 2: global history bits in the index.
- `bht_row_width_p`, default 4: row data width, equal to 2*2^`bht_offset_width_p`.
- `els_p`, default 4: queue depth; must be a power of 2 and at least 2.
- `starve_thresh_p`, default 8: consecutive refused cycles before `starve_o` asserts.

Ports:
- `clk_i` in, 1: clock.
- `reset_n_i` in, 1: reset, synchronous, active-low.
- `flush_i` in, 1: discard all queued updates.
- `bht_init_done_i` in, 1: BHT init sweep complete.
- `upd_v_i` in, 1: update valid.
- `upd_ready_o` out, 1: update accepted when `upd_v_i & upd_ready_o`.
- `upd_idx_i` in, `bht_idx_width_p`: row index.
- `upd_offset_i` in, `bht_offset_width_p`: counter offset.
- `upd_ghist_i` in, `ghist_width_p`: history used at prediction.
- `upd_val_i` in, `bht_row_width_p`: row value read at prediction.
- `upd_correct_i` in, 1: prediction was correct.
- `w_v_o` out, 1: head entry presented to the BHT.
- `w_idx_o` out, `bht_idx_width_p`: head field.
- `w_offset_o` out, `bht_offset_width_p`: head field.
- `w_ghist_o` out, `ghist_width_p`: head field.
- `w_val_o` out, `bht_row_width_p`: head field.
- `w_correct_o` out, 1: head field.
- `w_yumi_i` in, 1: BHT consumed the head this cycle. Legal only while `w_v_o` is high.
- `count_o` out, `$clog2(els_p+1)`: occupancy.
- `starve_o` out, 1: head refused for `starve_thresh_p` or more consecutive cycles.

## Operation
- Circular buffer with `els_p` entries. Read and write pointers are `$clog2(els_p)+1` bits; the extra bit distinguishes full from empty.
  - Empty: pointers are equal.
  - Full: pointers differ only in the MSB.
  - Pointers wrap modulo 2·`els_p`.
- Control FSM has two states.
  - `e_wait`: entered on reset and on deassertion of `bht_init_done_i`. Enqueue is allowed; `w_v_o` is held at 0.
  - `e_run`: entered from `e_wait` in the cycle after `bht_init_done_i` is sampled high. In this state, `w_v_o = ~empty`.
  - From `e_run`, a low `bht_init_done_i` returns the FSM to `e_wait`. Entries are kept.
- `upd_ready_o = reset_n_i & ~full & ~flush_i`. There is no enqueue when full, even if a dequeue happens in the same cycle. There is no bypass path.
- Enqueue writes the packed entry {ghist, idx, offset, val, correct} at the write pointer and increments the write pointer.
- Dequeue happens on `w_yumi_i`: the read pointer increments. `w_*_o` always reflect the entry at the read pointer.
- `w_yumi_i` while `w_v_o` is 0 is an illegal stimulus: it is ignored and flagged by an assertion.
- Enqueue and dequeue in the same cycle: both take effect and `count_o` is unchanged.
- Flush has priority over both enqueue and dequeue.
  - Both pointers reset to 0 at the next edge.
  - `starve_cnt` is cleared.
  - An enqueue attempted in the flush cycle is dropped; `upd_ready_o` is already 0 in that cycle.
- Starvation counter `starve_cnt`, `$clog2(starve_thresh_p+1)` bits:
  - Increments when `w_v_o & ~w_yumi_i`, saturating at `starve_thresh_p`.
  - Clears on `w_yumi_i`, on flush, when empty, or in `e_wait`.
  - `starve_o = (starve_cnt == starve_thresh_p)`.
- Entry order is strict FIFO. Updates to the same BHT address are never merged or reordered.

## Timing
- Reset (`reset_n_i` low at an edge) gives:
  - state `e_wait`, pointers 0, `starve_cnt` 0.
  - `w_v_o` 0, `count_o` 0, `starve_o` 0.
  - `upd_ready_o` 0 combinationally while `reset_n_i` is low.
  - Entry RAM contents are don't-care.
- Reset asserted mid-operation discards all entries. It overrides flush and handshakes in the same cycle.
- Enqueue-to-`w_v_o` latency is 1 cycle when in `e_run` and empty.
- Throughput is 1 update per cycle in steady state.
- `count_o`, `starve_o`, `w_*_o` and `w_v_o` are functions of registered state only, so they are glitch-free for the BHT.
- `bht_init_done_i` rising at edge N: `w_v_o` can first be 1 in cycle N+1.

## Test plan
- Reset, then `bht_init_done_i` held at 0 and 3 updates enqueued → `count_o`=3, `w_v_o`=0. Raise `bht_init_done_i` → `w_v_o`=1 next cycle with the first entry's fields. Yumi each cycle → drains in order, `count_o` goes 3→2→1→0.
- Fill to 4 with `w_yumi_i`=0 → `upd_ready_o`=0. Hold `upd_v_i` high with yumi asserted → no enqueue in the yumi cycle; accepted the following cycle, `count_o` stays at 4→3→4.
- Entry at head with `w_yumi_i` held at 0 for 8 cycles → `starve_o` rises in cycle 8 after `w_v_o` asserts. One yumi → `starve_o` returns to 0 the next cycle.
- `count_o`=2, then `flush_i` together with `upd_v_i` and `w_yumi_i` → `count_o`=0 next cycle and the new update is not stored.
- 20 enqueue/dequeue pairs with random idx/val at a steady occupancy of 1 → pointers wrap and output order matches a scoreboard exactly.
- `reset_n_i` low for 1 cycle with `count_o`=3 in `e_run` → all outputs return to reset values; the first post-reset enqueue is not drained until `bht_init_done_i` is seen high.
